// File: rtl/qvga_pkg.sv
`default_nettype none
// ------------------------------------------------------------------
// qvga_pkg : shared constants and state encoding for QVGA capture
// Rev 1.0
// ------------------------------------------------------------------
package qvga_pkg;

  localparam int QVGA_H_RES  = 320;
  localparam int QVGA_V_RES  = 240;
  localparam int QVGA_ADDR_W = 17;
  localparam int RGB565_W    = 16;

  typedef enum logic [1:0] {
    SYNC   = 2'd0,
    VBLANK = 2'd1,
    SKIP   = 2'd2,
    ACTIVE = 2'd3
  } cap_state_e;

endpackage
`default_nettype wire

// File: rtl/qvga_cam_capture_byte_pair.sv
`default_nettype none
// ------------------------------------------------------------------
// rgb565_byte_pair : joins two camera bytes into one RGB565 pixel
// Rev 1.0
// ------------------------------------------------------------------
module rgb565_byte_pair
  import qvga_pkg::*;
(
  input  logic                clk,
  input  logic                reset,
  input  logic                byte_en,
  input  logic                clear,
  input  logic [7:0]          cam_data,
  output logic                byte_phase,
  output logic                pixel_valid,
  output logic [RGB565_W-1:0] pixel
);

  logic       byte_phase_q, byte_phase_d;
  logic [7:0] hi_byte_q, hi_byte_d;

  always_comb begin
    byte_phase_d = byte_phase_q;
    hi_byte_d    = hi_byte_q;
    if (clear) begin
      byte_phase_d = 1'b0;
    end else if (byte_en) begin
      if (!byte_phase_q) begin
        hi_byte_d    = cam_data;
        byte_phase_d = 1'b1;
      end else begin
        byte_phase_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      byte_phase_q <= 1'b0;
      hi_byte_q    <= 8'h00;
    end else begin
      byte_phase_q <= byte_phase_d;
      hi_byte_q    <= hi_byte_d;
    end
  end

  assign byte_phase  = byte_phase_q;
  assign pixel_valid = byte_en & byte_phase_q;
  assign pixel       = {hi_byte_q, cam_data};

endmodule
`default_nettype wire

// File: rtl/qvga_cam_capture.sv
`default_nettype none
// ------------------------------------------------------------------
// qvga_cam_capture : OV7670-style byte stream to QVGA frame-buffer writes
// Rev 1.0
// ------------------------------------------------------------------
module qvga_cam_capture
  import qvga_pkg::*;
#(
  parameter int H_RES  = QVGA_H_RES,
  parameter int V_RES  = QVGA_V_RES,
  parameter int ADDR_W = QVGA_ADDR_W
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                cap_en,
  input  logic                vsync,
  input  logic                href,
  input  logic [7:0]          cam_data,
  output logic                we,
  output logic [ADDR_W-1:0]   wAddr,
  output logic [RGB565_W-1:0] wData,
  output logic                frame_done,
  output logic                frame_err,
  output logic                busy
);

  localparam int X_W = $clog2(H_RES + 1);
  localparam int Y_W = $clog2(V_RES + 2);
  localparam logic [X_W-1:0]    X_END     = X_W'(H_RES);
  localparam logic [Y_W-1:0]    Y_END     = Y_W'(V_RES);
  localparam logic [Y_W-1:0]    Y_SAT     = Y_W'(V_RES + 1);
  localparam logic [ADDR_W-1:0] LINE_STEP = ADDR_W'(H_RES);

  cap_state_e          state_q, state_d;
  logic [X_W-1:0]      x_q, x_d;
  logic [Y_W-1:0]      y_q, y_d;
  logic [ADDR_W-1:0]   line_base_q, line_base_d;
  logic                err_acc_q, err_acc_d;
  logic                href_d_q, href_d_d;
  logic                we_q, we_d;
  logic [ADDR_W-1:0]   waddr_q, waddr_d;
  logic [RGB565_W-1:0] wdata_q, wdata_d;
  logic                frame_done_q, frame_done_d;
  logic                frame_err_q, frame_err_d;
  logic                busy_q, busy_d;

  logic                live, line_end, byte_en, pair_clear;
  logic                byte_phase, pixel_valid;
  logic [RGB565_W-1:0] pixel;

  // vsync outranks href: once it rises, nothing from the line is processed
  assign live       = (state_q == ACTIVE) && !vsync;
  assign line_end   = live && href_d_q && !href;
  assign byte_en    = live && href;
  assign pair_clear = line_end || ((state_q == VBLANK) && !vsync);

  rgb565_byte_pair u_byte_pair (
    .clk         (clk),
    .reset       (reset),
    .byte_en     (byte_en),
    .clear       (pair_clear),
    .cam_data    (cam_data),
    .byte_phase  (byte_phase),
    .pixel_valid (pixel_valid),
    .pixel       (pixel)
  );

  always_comb begin
    state_d      = state_q;
    x_d          = x_q;
    y_d          = y_q;
    line_base_d  = line_base_q;
    err_acc_d    = err_acc_q;
    href_d_d     = href;
    we_d         = 1'b0;
    waddr_d      = waddr_q;
    wdata_d      = wdata_q;
    frame_done_d = 1'b0;
    frame_err_d  = frame_err_q;

    case (state_q)
      SYNC: begin
        if (vsync) state_d = VBLANK;
      end
      VBLANK: begin
        if (!vsync) begin
          if (cap_en) begin
            state_d     = ACTIVE;
            x_d         = '0;
            y_d         = '0;
            line_base_d = '0;
            waddr_d     = '0;
            err_acc_d   = 1'b0;
          end else begin
            state_d = SKIP;
          end
        end
      end
      SKIP: begin
        if (vsync) state_d = VBLANK;
      end
      ACTIVE: begin
        if (vsync) begin
          state_d      = VBLANK;
          frame_done_d = (y_q == Y_END) && !err_acc_q;
          frame_err_d  = err_acc_q || (y_q != Y_END);
        end else begin
          if (pixel_valid) begin
            if ((x_q < X_END) && (y_q < Y_END)) begin
              we_d    = 1'b1;
              wdata_d = pixel;
              waddr_d = line_base_q + ADDR_W'(x_q);
              x_d     = x_q + X_W'(1);
            end else begin
              err_acc_d = 1'b1;
            end
          end
          if (line_end) begin
            if ((x_q != X_END) || byte_phase) err_acc_d = 1'b1;
            x_d = '0;
            // Stop advancing once past the last line so extra lines cannot wrap
            if (y_q < Y_END) line_base_d = line_base_q + LINE_STEP;
            if (y_q != Y_SAT) y_d = y_q + Y_W'(1);
          end
        end
      end
      default: state_d = SYNC;
    endcase

    busy_d = (state_d == ACTIVE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= SYNC;
      x_q          <= '0;
      y_q          <= '0;
      line_base_q  <= '0;
      err_acc_q    <= 1'b0;
      href_d_q     <= 1'b0;
      we_q         <= 1'b0;
      waddr_q      <= '0;
      wdata_q      <= '0;
      frame_done_q <= 1'b0;
      frame_err_q  <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      x_q          <= x_d;
      y_q          <= y_d;
      line_base_q  <= line_base_d;
      err_acc_q    <= err_acc_d;
      href_d_q     <= href_d_d;
      we_q         <= we_d;
      waddr_q      <= waddr_d;
      wdata_q      <= wdata_d;
      frame_done_q <= frame_done_d;
      frame_err_q  <= frame_err_d;
      busy_q       <= busy_d;
    end
  end

  assign we         = we_q;
  assign wAddr      = waddr_q;
  assign wData      = wdata_q;
  assign frame_done = frame_done_q;
  assign frame_err  = frame_err_q;
  assign busy       = busy_q;

endmodule
`default_nettype wire
